// File: rtl/neuron_mac_if.sv
// Handshake bundle between the input stream, weight memory read port and activation stage.
// Latency: none, wiring only.
// Backpressure: in_ready is returned from the MAC; the weight port has none.
interface neuron_mac_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 10
);
  logic                     in_valid;
  logic [DATA_WIDTH-1:0]    in_data;
  logic                     in_ready;
  logic                     w_r_en;
  logic [ADDRESS_WIDTH-1:0] w_r_add;
  logic [DATA_WIDTH-1:0]    w_in;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_valid;

  // Upstream / memory / downstream side
  modport master (
    output in_valid, in_data, w_in,
    input  in_ready, w_r_en, w_r_add, out_data, out_valid
  );

  // Neuron MAC side
  modport slave (
    input  in_valid, in_data, w_in,
    output in_ready, w_r_en, w_r_add, out_data, out_valid
  );
endinterface

// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate: sum(in*w) + BIAS, rounded down and saturated to DATA_WIDTH.
// Latency: last input transfer in cycle T -> out_valid pulse in cycle T+3.
// Backpressure: in_ready drops for the two cycles that drain and sum each frame.
module neuron_mac #(
  parameter int NUM_WEIGHT    = 3,
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 16,
  parameter int FRAC_BITS     = 8,
  parameter int ACC_WIDTH     = 40,
  parameter logic signed [DATA_WIDTH-1:0] BIAS = '0
) (
  input  logic          clk,
  input  logic          rst,
  neuron_mac_if.slave   bus
);

  typedef enum logic [1:0] {S_ACC, S_WAIT, S_SUM} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] CNT_LAST = ADDRESS_WIDTH'(NUM_WEIGHT - 1);
  // Bias aligned to the accumulator's 2*FRAC_BITS binary point
  localparam logic signed [ACC_WIDTH-1:0] BIAS_ACC =
    {{(ACC_WIDTH-DATA_WIDTH){BIAS[DATA_WIDTH-1]}}, BIAS} <<< FRAC_BITS;
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_t                          state, state_nxt;
  logic [ADDRESS_WIDTH-1:0]        count;
  logic                            in_rdy;
  logic                            xfer;
  logic                            sum_en;
  logic                            s1_vld;
  logic signed [DATA_WIDTH-1:0]    s1_data;
  logic signed [2*DATA_WIDTH-1:0]  prod;
  logic signed [ACC_WIDTH-1:0]     prod_ext;
  logic signed [ACC_WIDTH-1:0]     acc;
  logic signed [ACC_WIDTH-1:0]     biased;
  logic signed [ACC_WIDTH-1:0]     shifted;
  logic [DATA_WIDTH-1:0]           result;
  logic [DATA_WIDTH-1:0]           out_data_q;
  logic                            out_valid_q;

  assign xfer         = bus.in_valid & in_rdy;
  assign bus.in_ready = in_rdy;
  assign bus.w_r_en   = xfer;
  assign bus.w_r_add  = count;
  assign bus.out_data = out_data_q;
  assign bus.out_valid = out_valid_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ACC;
    else     state <= state_nxt;
  end

  // Next-state: the last input of a frame starts the two-cycle drain
  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:   if (xfer && count == CNT_LAST) state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_SUM;
      S_SUM:   state_nxt = S_ACC;
      default: state_nxt = S_ACC;
    endcase
  end

  // State outputs; in_ready is also gated by rst so nothing is accepted during reset
  always_comb begin
    in_rdy = 1'b0;
    sum_en = 1'b0;
    case (state)
      S_ACC:   in_rdy = ~rst;
      S_SUM:   sum_en = 1'b1;
      default: ;
    endcase
  end

  // Input index, doubles as the weight memory address
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (xfer) count <= (count == CNT_LAST) ? '0 : count + ADDRESS_WIDTH'(1);
  end

  // Stage 1: hold the input while the weight memory read completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vld <= xfer;
      if (xfer) s1_data <= $signed(bus.in_data);
    end
  end

  // Full-precision product, sign-extended to the accumulator
  always_comb begin
    prod     = s1_data * $signed(bus.w_in);
    prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  end

  // Stage 2: accumulate; cleared when the frame result is captured
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         acc <= '0;
    else if (sum_en) acc <= '0;
    else if (s1_vld) acc <= acc + prod_ext;
  end

  // Add bias, drop fraction with floor, clamp to the output range
  always_comb begin
    biased  = acc + BIAS_ACC;
    shifted = biased >>> FRAC_BITS;
    if (shifted > OUT_MAX)      result = OUT_MAX[DATA_WIDTH-1:0];
    else if (shifted < OUT_MIN) result = OUT_MIN[DATA_WIDTH-1:0];
    else                        result = shifted[DATA_WIDTH-1:0];
  end

  // Output register: data holds between one-cycle valid pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= sum_en;
      if (sum_en) out_data_q <= result;
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
module tb_neuron_mac;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [15:0] in_data;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  neuron_mac_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(10)) bus0 ();
  neuron_mac_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(10)) bus1 ();

  neuron_mac #(.NUM_WEIGHT(3), .ADDRESS_WIDTH(10), .DATA_WIDTH(16), .FRAC_BITS(8),
               .ACC_WIDTH(40), .BIAS(16'sh0000))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  neuron_mac #(.NUM_WEIGHT(3), .ADDRESS_WIDTH(10), .DATA_WIDTH(16), .FRAC_BITS(8),
               .ACC_WIDTH(40), .BIAS(16'sh0100))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  logic [15:0] wmem [0:3];
  logic [15:0] wq   [2];
  logic        rdy  [2];
  logic        r_en [2];
  logic [9:0]  radd [2];
  logic [15:0] odat [2];
  logic        ovld [2];

  assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;
  assign bus0.in_data  = in_data;   assign bus1.in_data  = in_data;
  assign bus0.w_in     = wq[0];     assign bus1.w_in     = wq[1];
  assign rdy[0]  = bus0.in_ready;   assign rdy[1]  = bus1.in_ready;
  assign r_en[0] = bus0.w_r_en;     assign r_en[1] = bus1.w_r_en;
  assign radd[0] = bus0.w_r_add;    assign radd[1] = bus1.w_r_add;
  assign odat[0] = bus0.out_data;   assign odat[1] = bus1.out_data;
  assign ovld[0] = bus0.out_valid;  assign ovld[1] = bus1.out_valid;

  // Weight memory with a registered read port, one per DUT
  always @(posedge clk) begin
    if (r_en[0]) wq[0] <= wmem[radd[0][1:0]];
    if (r_en[1]) wq[1] <= wmem[radd[1][1:0]];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Reference: products summed as plain integers, bias scaled to the product point,
  // floor division by 2**8, clamp to 16-bit signed range.
  function automatic logic [15:0] ref_out(input longint sum, input longint bias);
    longint s;
    s = (sum + bias * 256) >>> 8;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  // Scoreboard per DUT: at most one result is outstanding at a time
  int     fidx     [2] = '{0, 0};
  longint facc     [2] = '{0, 0};
  bit     pend     [2] = '{0, 0};
  int     pend_due [2] = '{0, 0};
  logic [15:0] pend_val [2];
  int     pulses   [2] = '{0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        fidx[k] = 0;
        facc[k] = 0;
        pend[k] = 0;
      end else begin
        if (ovld[k]) begin
          pulses[k]++;
          chk(pend[k] && cyc == pend_due[k], "out_valid_timing", cyc, pend_due[k]);
          chk(odat[k] == pend_val[k], "model_out_data", odat[k], pend_val[k]);
          pend[k] = 0;
        end else if (pend[k] && cyc > pend_due[k]) begin
          chk(1'b0, "out_valid_missing", cyc, pend_due[k]);
          pend[k] = 0;
        end
        if (in_valid && rdy[k]) begin
          chk(r_en[k] == 1'b1 && radd[k] == 10'(fidx[k]), "w_r_add", radd[k], fidx[k]);
          facc[k] += longint'($signed(in_data)) * longint'($signed(wmem[fidx[k]]));
          fidx[k]++;
          if (fidx[k] == 3) begin
            pend[k]     = 1;
            pend_due[k] = cyc + 3;
            pend_val[k] = ref_out(facc[k], (k == 0) ? 0 : 256);
            facc[k]     = 0;
            fidx[k]     = 0;
          end
        end else begin
          chk(r_en[k] == 1'b0, "w_r_en_idle", r_en[k], 0);
        end
      end
    end
  end

  // Drive one input and hold it until accepted; returns the transfer cycle
  task automatic send_item(input logic [15:0] x, input int gap, output int tcyc);
    bit got;
    got  = 0;
    tcyc = -1;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = x;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (rdy[0]) begin tcyc = cyc; got = 1; end
    end
    if (got) begin @(posedge clk); #1; end
    chk(got, "transfer_timeout", got, 1);
  endtask

  task automatic wait_out(output logic [15:0] d0, output logic [15:0] d1);
    bit got;
    got = 0;
    d0  = 'x;
    d1  = 'x;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (ovld[0]) begin d0 = odat[0]; d1 = odat[1]; got = 1; end
    end
    chk(got, "out_valid_timeout", got, 1);
    @(posedge clk); #1;
  endtask

  logic [15:0] cur_x [3];

  task automatic run_frame(input int gapmax, output logic [15:0] d0, output logic [15:0] d1);
    int tc;
    for (int i = 0; i < 3; i++) send_item(cur_x[i], $urandom_range(0, gapmax), tc);
    in_valid = 1'b0;
    wait_out(d0, d1);
  endtask

  typedef struct {
    logic [15:0] w [3];
    logic [15:0] x [3];
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=stuck required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d0, d1;
    int tc [6];
    int p0;

    tbl[0].w = '{16'h0100, 16'h0200, 16'hFF00}; tbl[0].x = '{16'h0100, 16'h0100, 16'h0100};
    tbl[0].e0 = 16'h0200; tbl[0].e1 = 16'h0300;
    tbl[1].w = '{16'h7F00, 16'h7F00, 16'h7F00}; tbl[1].x = '{16'h7F00, 16'h7F00, 16'h7F00};
    tbl[1].e0 = 16'h7FFF; tbl[1].e1 = 16'h7FFF;
    tbl[2].w = '{16'h7F00, 16'h7F00, 16'h7F00}; tbl[2].x = '{16'h8100, 16'h8100, 16'h8100};
    tbl[2].e0 = 16'h8000; tbl[2].e1 = 16'h8000;
    tbl[3].w = '{16'h0100, 16'h0200, 16'hFF00}; tbl[3].x = '{16'h0000, 16'h0000, 16'h0000};
    tbl[3].e0 = 16'h0000; tbl[3].e1 = 16'h0100;
    tbl[4].w = '{16'h0001, 16'h0000, 16'h0000}; tbl[4].x = '{16'hFFFF, 16'h0000, 16'h0000};
    tbl[4].e0 = 16'hFFFF; tbl[4].e1 = 16'h00FF;
    tbl[5].w = '{16'h0080, 16'h0080, 16'h0080}; tbl[5].x = '{16'h0300, 16'hFD00, 16'h0100};
    tbl[5].e0 = 16'h0080; tbl[5].e1 = 16'h0180;

    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < 4; i++) wmem[i] = '0;

    // Reset state
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk(rdy[k] == 1'b0,  "reset_in_ready", rdy[k], 0);
      chk(ovld[k] == 1'b0, "reset_out_valid", ovld[k], 0);
      chk(odat[k] == '0,   "reset_out_data", odat[k], 0);
      chk(radd[k] == '0,   "reset_w_r_add", radd[k], 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk(rdy[0] == 1'b1, "post_reset_in_ready", rdy[0], 1);
    @(posedge clk); #1;

    // Directed table
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 3; i++) begin wmem[i] = tbl[t].w[i]; cur_x[i] = tbl[t].x[i]; end
      run_frame(0, d0, d1);
      chk(d0 == tbl[t].e0, $sformatf("table%0d_bias0", t), d0, tbl[t].e0);
      chk(d1 == tbl[t].e1, $sformatf("table%0d_bias1", t), d1, tbl[t].e1);
    end

    // Two frames with in_valid held high throughout
    for (int i = 0; i < 3; i++) wmem[i] = tbl[0].w[i];
    p0 = pulses[0];
    for (int i = 0; i < 6; i++) send_item(16'h0100, 0, tc[i]);
    in_valid = 1'b0;
    wait_out(d0, d1);
    chk(tc[3] - tc[2] == 3, "frame_gap_cycles", tc[3] - tc[2], 3);
    chk(tc[1] - tc[0] == 1, "back_to_back_accept", tc[1] - tc[0], 1);
    chk(pulses[0] - p0 == 2, "two_frame_pulses", pulses[0] - p0, 2);
    chk(d0 == 16'h0200, "second_frame_data", d0, 16'h0200);

    // Random gaps inside a frame
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) cur_x[i] = 16'h0100;
      run_frame(3, d0, d1);
      chk(d0 == 16'h0200, "gapped_frame_bias0", d0, 16'h0200);
      chk(d1 == 16'h0300, "gapped_frame_bias1", d1, 16'h0300);
    end

    // Reset after two transfers discards the partial frame
    send_item(16'h7F00, 0, tc[0]);
    send_item(16'h7F00, 0, tc[1]);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk(rdy[0] == 1'b0, "in_ready_during_reset", rdy[0], 0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    p0 = pulses[0];
    for (int i = 0; i < 3; i++) cur_x[i] = 16'h0100;
    run_frame(0, d0, d1);
    chk(d0 == 16'h0200, "after_reset_bias0", d0, 16'h0200);
    chk(d1 == 16'h0300, "after_reset_bias1", d1, 16'h0300);
    chk(pulses[0] - p0 == 1, "after_reset_pulses", pulses[0] - p0, 1);

    // Random frames against the reference model
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 3; i++) begin
        wmem[i]  = 16'($urandom);
        cur_x[i] = 16'($urandom);
      end
      if (r % 3 == 0) begin
        wmem[0] = 16'($urandom_range(0, 511)) - 16'd256;
        cur_x[0] = 16'($urandom_range(0, 511)) - 16'd256;
      end
      run_frame(2, d0, d1);
    end

    repeat (5) @(posedge clk);
    #1;
    chk(pend[0] == 0 && pend[1] == 0, "no_result_outstanding", pend[0] + pend[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
